// File: rtl/sym_pkg.sv
// Shared types, widths and the work-LFSR step function for the symbol-memory game.
package sym_pkg;

  localparam int SYM_W  = 2;
  localparam int LFSR_W = 8;

  // Feedback taps on bits 7, 5, 4 and 3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_SHOW,
    ST_INPUT,
    ST_FAIL,
    ST_WIN
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sym_lfsr.sv
// Work LFSR that replays the level's symbol sequence; load wins over advance.
module sym_lfsr
  import sym_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              advance_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [SYM_W-1:0]  sym_o
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (advance_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign sym_o   = state_q[SYM_W-1:0];

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: starts the timer per level, shows the symbol sequence,
// then checks the player's entries against a replay of the same sequence.
module level_sequencer
  import sym_pkg::*;
#(
  parameter int unsigned MAX_LEVEL     = 9,
  parameter int unsigned TIMEOUT_TICKS = 5,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic             Clk100M_i,
  input  logic             Rst_n_i,
  input  logic             tick_i,
  input  logic             playBtn_i,
  input  logic             btnValid_i,
  input  logic [SYM_W-1:0] btnSym_i,
  input  logic             doneCounting_i,
  output logic             start_o,
  output logic [3:0]       curLevel_o,
  output logic             symValid_o,
  output logic [SYM_W-1:0] symOut_o,
  output logic             levelPass_o,
  output logic             gameOver_o,
  output logic             win_o
);

  localparam int              TO_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]      MAX_LVL = 4'(MAX_LEVEL);

  state_e state_q, state_d;

  logic [LFSR_W-1:0] seedCnt_q;
  logic [LFSR_W-1:0] gameSeed_q, gameSeed_d;
  logic [3:0]        curLevel_q, curLevel_d;
  logic [3:0]        idx_q, idx_d;
  logic [TO_W-1:0]   toCnt_q, toCnt_d;

  logic             start_q, start_d;
  logic             levelPass_q, levelPass_d;
  logic             symValid_q, symValid_d;
  logic [SYM_W-1:0] symOut_q, symOut_d;
  logic             gameOver_q, gameOver_d;
  logic             win_q, win_d;

  logic             lfsrLoad, lfsrAdvance;
  logic [SYM_W-1:0] lfsrSym;
  logic             showMore, lastSym;

  sym_lfsr u_lfsr (
    .clk_i     (Clk100M_i),
    .rst_n_i   (Rst_n_i),
    .load_i    (lfsrLoad),
    .seed_i    (gameSeed_q),
    .advance_i (lfsrAdvance),
    .state_o   (),
    .sym_o     (lfsrSym)
  );

  assign showMore = (idx_q < curLevel_q);
  assign lastSym  = (idx_q == (curLevel_q - 4'd1));

  always_ff @(posedge Clk100M_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q     <= ST_IDLE;
      seedCnt_q   <= '0;
      gameSeed_q  <= '0;
      curLevel_q  <= '0;
      idx_q       <= '0;
      toCnt_q     <= '0;
      start_q     <= 1'b0;
      levelPass_q <= 1'b0;
      symValid_q  <= 1'b0;
      symOut_q    <= '0;
      gameOver_q  <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      seedCnt_q   <= seedCnt_q + 8'd1;
      gameSeed_q  <= gameSeed_d;
      curLevel_q  <= curLevel_d;
      idx_q       <= idx_d;
      toCnt_q     <= toCnt_d;
      start_q     <= start_d;
      levelPass_q <= levelPass_d;
      symValid_q  <= symValid_d;
      symOut_q    <= symOut_d;
      gameOver_q  <= gameOver_d;
      win_q       <= win_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gameSeed_d  = gameSeed_q;
    curLevel_d  = curLevel_q;
    idx_d       = idx_q;
    toCnt_d     = toCnt_q;
    lfsrLoad    = 1'b0;
    lfsrAdvance = 1'b0;
    case (state_q)
      ST_IDLE, ST_FAIL, ST_WIN: begin
        if (playBtn_i) begin
          gameSeed_d = (seedCnt_q == '0) ? LFSR_SEED : seedCnt_q;
          curLevel_d = 4'd1;
          state_d    = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (doneCounting_i) begin
          lfsrLoad = 1'b1;
          idx_d    = '0;
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (tick_i) begin
          if (showMore) begin
            lfsrAdvance = 1'b1;
            idx_d       = idx_q + 4'd1;
          end else begin
            // Rewind so the input phase replays the sequence from its start.
            lfsrLoad = 1'b1;
            idx_d    = '0;
            toCnt_d  = '0;
            state_d  = ST_INPUT;
          end
        end
      end
      ST_INPUT: begin
        if (btnValid_i) begin
          toCnt_d = '0;
          if (btnSym_i != lfsrSym) begin
            state_d = ST_FAIL;
          end else if (!lastSym) begin
            lfsrAdvance = 1'b1;
            idx_d       = idx_q + 4'd1;
          end else if (curLevel_q == MAX_LVL) begin
            state_d = ST_WIN;
          end else begin
            curLevel_d = curLevel_q + 4'd1;
            state_d    = ST_COUNT;
          end
        end else if (tick_i) begin
          if (toCnt_q == TO_LAST) begin
            state_d = ST_FAIL;
          end else begin
            toCnt_d = toCnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulses fall out of state transitions; the level-up path is the only INPUT->COUNT edge.
  always_comb begin
    start_d     = (state_d == ST_COUNT) && (state_q != ST_COUNT);
    levelPass_d = (state_d == ST_COUNT) && (state_q == ST_INPUT);
    gameOver_d  = (state_d == ST_FAIL);
    win_d       = (state_d == ST_WIN);
    symValid_d  = 1'b0;
    symOut_d    = symOut_q;
    if (state_q == ST_SHOW) begin
      symValid_d = tick_i ? showMore : symValid_q;
      if (tick_i && showMore) begin
        symOut_d = lfsrSym;
      end
    end
  end

  assign start_o     = start_q;
  assign curLevel_o  = curLevel_q;
  assign symValid_o  = symValid_q;
  assign symOut_o    = symOut_q;
  assign levelPass_o = levelPass_q;
  assign gameOver_o  = gameOver_q;
  assign win_o       = win_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: two instances (MAX_LEVEL 9 and 2) share stimulus and
// are checked every cycle against a sequence-level game model plus literal pins.
module tb_level_sequencer;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic tick = 1'b0, playBtn = 1'b0, btnValid = 1'b0, doneCounting = 1'b0;
  logic [1:0] btnSym = 2'd0;

  logic [1:0] startO, symValidO, levelPassO, gameOverO, winO;
  logic [3:0] levelO [2];
  logic [1:0] symOutO [2];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  level_sequencer #(.MAX_LEVEL(9), .TIMEOUT_TICKS(5), .LFSR_SEED(8'hA5)) dutA (
    .Clk100M_i(clk), .Rst_n_i(rstN), .tick_i(tick), .playBtn_i(playBtn),
    .btnValid_i(btnValid), .btnSym_i(btnSym), .doneCounting_i(doneCounting),
    .start_o(startO[0]), .curLevel_o(levelO[0]), .symValid_o(symValidO[0]),
    .symOut_o(symOutO[0]), .levelPass_o(levelPassO[0]), .gameOver_o(gameOverO[0]),
    .win_o(winO[0])
  );

  level_sequencer #(.MAX_LEVEL(2), .TIMEOUT_TICKS(5), .LFSR_SEED(8'hA5)) dutB (
    .Clk100M_i(clk), .Rst_n_i(rstN), .tick_i(tick), .playBtn_i(playBtn),
    .btnValid_i(btnValid), .btnSym_i(btnSym), .doneCounting_i(doneCounting),
    .start_o(startO[1]), .curLevel_o(levelO[1]), .symValid_o(symValidO[1]),
    .symOut_o(symOutO[1]), .levelPass_o(levelPassO[1]), .gameOver_o(gameOverO[1]),
    .win_o(winO[1])
  );

  localparam int M_IDLE = 0, M_TIMER = 1, M_SHOW = 2, M_ENTER = 3, M_OVER = 4, M_WON = 5;

  int mMode [2] = '{M_IDLE, M_IDLE};
  int mLevel [2] = '{0, 0};
  int mShown [2], mEntered [2], mQuiet [2];
  logic [7:0] mSeed [2];
  logic [7:0] mCnt = 8'd0;
  bit eStart [2] = '{0, 0};
  bit ePass [2] = '{0, 0};
  bit eValid [2] = '{0, 0};
  bit eOver [2] = '{0, 0};
  bit eWin [2] = '{0, 0};
  logic [1:0] eSym [2] = '{2'd0, 2'd0};

  function automatic int maxLevelOf(input int i);
    return (i == 0) ? 9 : 2;
  endfunction

  // k-th symbol of the sequence grown from seed.
  function automatic logic [1:0] symAt(input logic [7:0] seed, input int k);
    logic [7:0] l;
    l = seed;
    for (int s = 0; s < k; s++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l[1:0];
  endfunction

  initial begin : modelProc
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        mCnt = 8'd0;
        for (int i = 0; i < 2; i++) begin
          mMode[i] = M_IDLE; mLevel[i] = 0;
          eStart[i] = 0; ePass[i] = 0; eValid[i] = 0; eOver[i] = 0; eWin[i] = 0;
          eSym[i] = 2'd0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          eStart[i] = 0;
          ePass[i] = 0;
          case (mMode[i])
            M_IDLE, M_OVER, M_WON: if (playBtn) begin
              mSeed[i] = (mCnt == 8'd0) ? 8'hA5 : mCnt;
              mLevel[i] = 1; eOver[i] = 0; eWin[i] = 0; eStart[i] = 1;
              mMode[i] = M_TIMER;
            end
            M_TIMER: if (doneCounting) begin
              mShown[i] = 0; mMode[i] = M_SHOW;
            end
            M_SHOW: if (tick) begin
              if (mShown[i] < mLevel[i]) begin
                eValid[i] = 1; eSym[i] = symAt(mSeed[i], mShown[i]); mShown[i]++;
              end else begin
                eValid[i] = 0; mEntered[i] = 0; mQuiet[i] = 0; mMode[i] = M_ENTER;
              end
            end
            M_ENTER: begin
              if (btnValid) begin
                mQuiet[i] = 0;
                if (btnSym != symAt(mSeed[i], mEntered[i])) begin
                  mMode[i] = M_OVER; eOver[i] = 1;
                end else if (mEntered[i] == mLevel[i] - 1) begin
                  if (mLevel[i] == maxLevelOf(i)) begin
                    mMode[i] = M_WON; eWin[i] = 1;
                  end else begin
                    mLevel[i]++; ePass[i] = 1; eStart[i] = 1; mMode[i] = M_TIMER;
                  end
                end else begin
                  mEntered[i]++;
                end
              end else if (tick) begin
                mQuiet[i]++;
                if (mQuiet[i] == 5) begin
                  mMode[i] = M_OVER; eOver[i] = 1;
                end
              end
            end
            default: ;
          endcase
        end
        mCnt = mCnt + 8'd1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
    end
  endtask

  initial begin : compareProc
    forever begin
      @(negedge clk);
      if (rstN) begin
        for (int i = 0; i < 2; i++) begin
          checkOutput($sformatf("start[%0d]", i), 32'(startO[i]), 32'(eStart[i]));
          checkOutput($sformatf("curLevel[%0d]", i), 32'(levelO[i]), 32'(mLevel[i]));
          checkOutput($sformatf("symValid[%0d]", i), 32'(symValidO[i]), 32'(eValid[i]));
          if (eValid[i]) checkOutput($sformatf("symOut[%0d]", i), 32'(symOutO[i]), 32'(eSym[i]));
          checkOutput($sformatf("levelPass[%0d]", i), 32'(levelPassO[i]), 32'(ePass[i]));
          checkOutput($sformatf("gameOver[%0d]", i), 32'(gameOverO[i]), 32'(eOver[i]));
          checkOutput($sformatf("win[%0d]", i), 32'(winO[i]), 32'(eWin[i]));
        end
      end
    end
  end

  task automatic applyStimulus(input logic pb, input logic tk, input logic bv,
                               input logic [1:0] bs, input logic dc);
    playBtn = pb; tick = tk; btnValid = bv; btnSym = bs; doneCounting = dc;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic play();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic done();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic tickOnly();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic press(input logic [1:0] s);
    applyStimulus(1'b0, 1'b0, 1'b1, s, 1'b0);
  endtask

  task automatic showSyms(input int n);
    done();
    for (int k = 0; k <= n; k++) begin
      idle(2);
      tickOnly();
    end
  endtask

  task automatic checkAllClear(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s.start[%0d]", tag, i), 32'(startO[i]), 32'd0);
      checkOutput($sformatf("%s.curLevel[%0d]", tag, i), 32'(levelO[i]), 32'd0);
      checkOutput($sformatf("%s.symValid[%0d]", tag, i), 32'(symValidO[i]), 32'd0);
      checkOutput($sformatf("%s.symOut[%0d]", tag, i), 32'(symOutO[i]), 32'd0);
      checkOutput($sformatf("%s.levelPass[%0d]", tag, i), 32'(levelPassO[i]), 32'd0);
      checkOutput($sformatf("%s.gameOver[%0d]", tag, i), 32'(gameOverO[i]), 32'd0);
      checkOutput($sformatf("%s.win[%0d]", tag, i), 32'(winO[i]), 32'd0);
    end
  endtask

  initial begin : watchdog
    #500000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : stimulus
    logic [1:0] lvl3Exp [3];
    lvl3Exp = '{2'd1, 2'd2, 2'd0};

    checkOutput("pin.symAt01_2", 32'(symAt(8'h01, 2)), 32'd0);
    checkOutput("pin.symAtA5_0", 32'(symAt(8'hA5, 0)), 32'd1);

    repeat (3) @(negedge clk);
    #1;
    checkAllClear("reset");
    rstN = 1'b1;
    idle(1);

    // Seed counter reads 1 here.
    play();
    checkOutput("lvl1.start", 32'(startO[0]), 32'd1);
    checkOutput("lvl1.curLevel", 32'(levelO[0]), 32'd1);
    idle(1);
    checkOutput("lvl1.startOneCycle", 32'(startO[0]), 32'd0);
    done();
    idle(2);
    tickOnly();
    checkOutput("lvl1.symValid", 32'(symValidO[0]), 32'd1);
    checkOutput("lvl1.symOut", 32'(symOutO[0]), 32'd1);
    idle(2);
    tickOnly();
    checkOutput("lvl1.symValidOff", 32'(symValidO[0]), 32'd0);
    press(2'd1);
    checkOutput("lvl1.levelPass", 32'(levelPassO[0]), 32'd1);
    checkOutput("lvl1.startAgain", 32'(startO[0]), 32'd1);
    checkOutput("lvl1.curLevelNext", 32'(levelO[0]), 32'd2);

    showSyms(2);
    press(2'd1);
    press(2'd2);
    checkOutput("lvl2.curLevelA", 32'(levelO[0]), 32'd3);
    checkOutput("lvl2.winB", 32'(winO[1]), 32'd1);
    checkOutput("lvl2.levelPassB", 32'(levelPassO[1]), 32'd0);
    checkOutput("lvl2.startB", 32'(startO[1]), 32'd0);

    done();
    for (int k = 0; k < 3; k++) begin
      idle(2);
      tickOnly();
      checkOutput($sformatf("lvl3.sym%0d", k), 32'(symOutO[0]), 32'(lvl3Exp[k]));
    end
    idle(2);
    tickOnly();
    press(2'd1);
    press(2'd2);
    press(2'd0);
    checkOutput("lvl3.levelPass", 32'(levelPassO[0]), 32'd1);
    checkOutput("lvl3.start", 32'(startO[0]), 32'd1);
    checkOutput("lvl3.curLevel", 32'(levelO[0]), 32'd4);

    // Button on the 5th tick wins over the timeout.
    showSyms(4);
    repeat (4) begin idle(1); tickOnly(); end
    applyStimulus(1'b0, 1'b1, 1'b1, symAt(8'h01, 0), 1'b0);
    checkOutput("lvl4.noTimeout", 32'(gameOverO[0]), 32'd0);
    repeat (4) begin idle(1); tickOnly(); end
    checkOutput("lvl4.countRestarted", 32'(gameOverO[0]), 32'd0);
    for (int k = 1; k < 4; k++) press(symAt(8'h01, k));
    checkOutput("lvl4.curLevel", 32'(levelO[0]), 32'd5);

    showSyms(5);
    repeat (4) begin idle(1); tickOnly(); end
    checkOutput("lvl5.beforeTimeout", 32'(gameOverO[0]), 32'd0);
    idle(1);
    tickOnly();
    checkOutput("lvl5.timeout", 32'(gameOverO[0]), 32'd1);
    idle(3);
    checkOutput("lvl5.gameOverHeld", 32'(gameOverO[0]), 32'd1);

    play();
    checkOutput("replay.curLevelA", 32'(levelO[0]), 32'd1);
    checkOutput("replay.gameOverA", 32'(gameOverO[0]), 32'd0);
    checkOutput("replay.winB", 32'(winO[1]), 32'd0);

    done();
    idle(2);
    tickOnly();
    checkOutput("midShow.symValid", 32'(symValidO[0]), 32'd1);
    rstN = 1'b0;
    #1;
    checkAllClear("asyncReset");
    idle(2);
    rstN = 1'b1;

    // First edge after reset: counter is 0, so the fallback seed is used.
    play();
    done();
    idle(2);
    tickOnly();
    checkOutput("fallback.symValid", 32'(symValidO[0]), 32'd1);
    checkOutput("fallback.symOut", 32'(symOutO[0]), 32'd1);
    idle(2);
    tickOnly();
    press(2'd1);
    checkOutput("fallback.curLevel", 32'(levelO[0]), 32'd2);

    rstN = 1'b0;
    idle(2);
    rstN = 1'b1;
    idle(1);
    play();
    showSyms(1);
    press(2'd1);
    showSyms(2);
    press(2'd1);
    press(2'd3);
    checkOutput("wrong.gameOverA", 32'(gameOverO[0]), 32'd1);
    checkOutput("wrong.gameOverB", 32'(gameOverO[1]), 32'd1);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
    checkOutput("wrong.held", 32'(gameOverO[0]), 32'd1);
    checkOutput("wrong.levelHeld", 32'(levelO[0]), 32'd2);
    play();
    checkOutput("wrong.replayLevel", 32'(levelO[0]), 32'd1);
    checkOutput("wrong.replayClear", 32'(gameOverO[0]), 32'd0);
    checkOutput("wrong.replayStart", 32'(startO[0]), 32'd1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Game-flow controller for the symbol-memory game. For each level it starts the countdown timer with a start pulse and the current level number, then waits for the timer's done pulse. It then shows a pseudo-random symbol sequence whose length equals the level, and checks the player's button entries against that sequence, advancing on success and ending the game on error or timeout. It is the initiator side of the timer's start/doneCounting handshake and runs entirely in the Clk100M domain.

## Interface
- MAX_LEVEL, 9: final level; completing it asserts win (range 1..9).
- TIMEOUT_TICKS, 5: ticks with no press in the input phase before the game fails.
- LFSR_SEED, 8'hA5: seed substituted when the captured seed is zero.

- Clk100M  in  1  system clock; the only clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle 1 Hz strobe, synchronous to Clk100M.
- playBtn  in  1  one-cycle pulse, new-game request.
- btnValid  in  1  one-cycle pulse, player entry present.
- btnSym  in  2  entered symbol, sampled when btnValid=1.
- doneCounting  in  1  one-cycle pulse from the timer.
- start  out  1  one-cycle pulse to the timer.
- curLevel  out  4  current level, 1..MAX_LEVEL; 0 in IDLE.
- symValid  out  1  a sequence symbol is being shown.
- symOut  out  2  symbol shown while symValid=1.
- levelPass  out  1  one-cycle pulse on level completion.
- gameOver  out  1  held high in FAIL.
- win  out  1  held high in WIN.

## Operation
- States: IDLE, COUNT, SHOW, INPUT, FAIL, WIN.
- Seed counter: 8-bit, free-running, increments every cycle, 0 after reset. On playBtn, gameSeed is set to the counter value, or to LFSR_SEED if that value is 0.
- Work LFSR: 8-bit Fibonacci. next = {l[6:0], l[7]^l[5]^l[4]^l[3]}. The current symbol is l[1:0].
- IDLE, FAIL, WIN: playBtn captures the seed, sets curLevel=1, clears gameOver and win, and goes to COUNT. All other inputs are ignored.
- COUNT: start=1 on the first cycle in the state only. doneCounting causes: LFSR←gameSeed, idx←0, go to SHOW.
- SHOW: on each tick:
  - if idx<curLevel: symValid=1, symOut=l[1:0], advance LFSR, idx++.
  - otherwise: symValid=0, LFSR←gameSeed, idx←0, toCnt←0, go to INPUT.
- INPUT: on btnValid, toCnt←0, then:
  - btnSym≠l[1:0]: go to FAIL.
  - match, not the last symbol: advance LFSR, idx++.
  - match, last symbol (idx==curLevel-1), curLevel==MAX_LEVEL: go to WIN.
  - match, last symbol, curLevel<MAX_LEVEL: curLevel++, levelPass=1, go to COUNT.
- INPUT timeout: on tick with no btnValid, toCnt++. When toCnt reaches TIMEOUT_TICKS, go to FAIL.
- Ignored events:
  - playBtn outside IDLE/FAIL/WIN.
  - doneCounting outside COUNT.
  - btnValid outside INPUT.
  - tick outside SHOW/INPUT.
- Simultaneous events: btnValid and tick in the same INPUT cycle means the button is processed and the tick is not counted.

## Timing
- All outputs are registered.
- Reset values: start=0, curLevel=0, symValid=0, symOut=0, levelPass=0, gameOver=0, win=0. State=IDLE, seed counter=0.
- Reset asserted mid-game returns to IDLE immediately (asynchronous). No pulse output may be left high.
- start is high exactly one cycle: the cycle after playBtn, or the cycle after the accepting btnValid. levelPass is coincident with that start.
- symValid/symOut change only in the cycle after a tick. Each symbol is held for one tick period.
- A btnValid decision is visible one cycle after the pulse.
- gameOver and win remain high until the next playBtn is accepted.

## Structure
- Package sym_pkg:
  - state enum.
  - SYM_W=2.
  - LFSR tap constant.
  - function lfsr_next.
- Sub-module sym_lfsr holds the work LFSR, with inputs load, seed and advance, and outputs state and sym.
- The top level holds the FSM, idx/toCnt/curLevel counters and the seed counter.

## Test plan
- Reset, then playBtn with gameSeed=8'h01 → next cycle start=1 for 1 cycle and curLevel=1. After doneCounting, the next tick gives symValid=1, symOut=1. The following tick gives symValid=0 and the block enters INPUT.
- Level 3 with seed 8'h01: shown symbols 1,2,0. Entering 1,2,0 → levelPass and start pulse in the same cycle, curLevel=4.
- Seed 8'h01 at level 2, entering 1 then 3 → gameOver=1 one cycle after the second btnValid. Stays high until playBtn, which gives curLevel=1, gameOver=0.
- In INPUT, no press for 5 ticks → gameOver=1 after the 5th tick. A btnValid coincident with the 5th tick is processed instead, and no timeout occurs.
- MAX_LEVEL=2, all entries correct → win=1 after level 2, levelPass stays 0, no start pulse.
- Rst_n low mid-SHOW → all outputs reset immediately. playBtn with seed counter 0 → LFSR_SEED is used, and the first symbol is 2'b01.
